cnt_sweep_ctrl: RTL and testbench

CNT_SWEEP_CTRL -- requirements
Module: cnt_sweep_ctrl

---
 rtl/cnt_sweep_ctrl.sv | 107 ++++++++++
 tb/tb_cnt_sweep_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/cnt_sweep_ctrl.sv
// Two-requester round-robin sweep controller driving a shared up/down counter.
// Optional abort input enabled by defining SWEEP_ABORT_EN.
module cnt_sweep_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic             dir0,
    input  logic             dir1,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
`ifdef SWEEP_ABORT_EN
    input  logic             abort,
`endif
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] cnt_out
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic             prio;
    logic             win;
    logic             win_id;
    logic             dir;
    logic             stop;
    logic [WIDTH-1:0] rem;

    // prio names the requester that wins a tie
    always_comb win = (req == 2'b11) ? prio : req[1];

`ifdef SWEEP_ABORT_EN
    assign stop = abort;
`else
    assign stop = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            prio    <= 1'b0;
            win_id  <= 1'b0;
            dir     <= 1'b0;
            rem     <= '0;
            gnt     <= 2'b00;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            cnt_out <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        state   <= LOAD;
                        busy    <= 1'b1;
                        gnt     <= win ? 2'b10 : 2'b01;
                        win_id  <= win;
                        prio    <= ~win;
                        dir     <= win ? dir1 : dir0;
                        rem     <= win ? len1 : len0;
                        cnt_out <= (win ? dir1 : dir0) ? '1 : '0;
                    end
                end
                LOAD: begin
                    if (stop || rem == '0) begin
                        state   <= DONE;
                        gnt     <= 2'b00;
                        done    <= 1'b1;
                        done_id <= win_id;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state   <= DONE;
                        gnt     <= 2'b00;
                        done    <= 1'b1;
                        done_id <= win_id;
                    end else begin
                        cnt_out <= dir ? cnt_out - ONE : cnt_out + ONE;
                        rem     <= rem - ONE;
                        // last step: the count reaches zero on this edge
                        if (rem == ONE) begin
                            state   <= DONE;
                            gnt     <= 2'b00;
                            done    <= 1'b1;
                            done_id <= win_id;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnt_sweep_ctrl.sv
// Directed scoreboard bench for cnt_sweep_ctrl (WIDTH=4).
module tb_cnt_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic       dir0, dir1;
    logic [3:0] len0, len1;
`ifdef SWEEP_ABORT_EN
    logic       abort = 1'b0;
`endif
    logic [1:0] gnt;
    logic       busy, done, done_id;
    logic [3:0] cnt_out;

    typedef struct {
        logic       id;
        logic [3:0] fin;
        logic [3:0] len;
    } rec_t;

    rec_t sb[$];
    int   total = 0;
    int   bad = 0;
    logic prio;

    cnt_sweep_ctrl #(.WIDTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .dir0(dir0),
        .dir1(dir1),
        .len0(len0),
        .len1(len1),
`ifdef SWEEP_ABORT_EN
        .abort(abort),
`endif
        .gnt(gnt),
        .busy(busy),
        .done(done),
        .done_id(done_id),
        .cnt_out(cnt_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // starts at a negedge in IDLE, ends at the negedge of the following IDLE cycle
    task automatic sweep(input logic [1:0] r, input logic d0, input logic d1,
                         input logic [3:0] l0, input logic [3:0] l1,
                         input bit hold);
        logic       w, d;
        logic [3:0] l, exp_cnt, fin;
        int         k;
        rec_t       rec;
        w = (r == 2'b11) ? prio : r[1];
        prio = ~w;
        d = w ? d1 : d0;
        l = w ? l1 : l0;
        exp_cnt = d ? 4'hF : 4'h0;
        fin = d ? exp_cnt - l : exp_cnt + l;
        sb.push_back('{id: w, fin: fin, len: l});
        req = r; dir0 = d0; dir1 = d1; len0 = l0; len1 = l1;
        @(posedge clk);
        @(negedge clk);
        chk("load_gnt", 32'(gnt), w ? 32'h2 : 32'h1);
        chk("load_cnt", 32'(cnt_out), 32'(exp_cnt));
        chk("load_busy", 32'(busy), 32'h1);
        if (!hold) req = 2'b00;
        dir0 = ~d0; dir1 = ~d1; len0 = 4'h7; len1 = 4'h7;
        k = 1;
        while (!done && k < 40) begin
            if (k >= 2) begin
                chk("run_gnt", 32'(gnt), w ? 32'h2 : 32'h1);
                chk("run_cnt", 32'(cnt_out), 32'(exp_cnt));
                exp_cnt = d ? exp_cnt - 4'h1 : exp_cnt + 4'h1;
            end
            @(negedge clk);
            k++;
        end
        chk("done_seen", 32'(done), 32'h1);
        rec = sb.pop_front();
        chk("latency", 32'(k), 32'(rec.len) + 32'd2);
        chk("done_id", 32'(done_id), 32'(rec.id));
        chk("done_cnt", 32'(cnt_out), 32'(rec.fin));
        chk("done_gnt", 32'(gnt), 32'h0);
        @(negedge clk);
        chk("idle_done", 32'(done), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);
        chk("idle_cnt", 32'(cnt_out), 32'(rec.fin));
    endtask

    initial begin
        int k;
        rst = 1'b1; req = 2'b00; dir0 = 1'b0; dir1 = 1'b0;
        len0 = 4'h0; len1 = 4'h0;
        prio = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_id", 32'(done_id), 32'h0);
        chk("rst_cnt", 32'(cnt_out), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        sweep(2'b01, 1'b0, 1'b0, 4'd5, 4'd0, 1'b0);
        sweep(2'b10, 1'b0, 1'b1, 4'd0, 4'd3, 1'b0);
        sweep(2'b01, 1'b0, 1'b0, 4'd0, 4'd9, 1'b0);
        sweep(2'b01, 1'b0, 1'b0, 4'd15, 4'd0, 1'b0);
        sweep(2'b10, 1'b0, 1'b1, 4'd0, 4'd15, 1'b0);

        // abort a sweep with reset once the counter shows 3
        req = 2'b01; dir0 = 1'b0; len0 = 4'd8;
        @(posedge clk);
        @(negedge clk);
        req = 2'b00;
        k = 0;
        while (cnt_out !== 4'd3 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("pre_rst_cnt", 32'(cnt_out), 32'h3);
        rst = 1'b1;
        prio = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_cnt", 32'(cnt_out), 32'h0);
        chk("mid_rst_done", 32'(done), 32'h0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_done", 32'(done), 32'h0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_done", 32'(done), 32'h0);
        chk("post_rst_busy", 32'(busy), 32'h0);

        sweep(2'b11, 1'b1, 1'b0, 4'd2, 4'd4, 1'b1);
        sweep(2'b11, 1'b1, 1'b0, 4'd2, 4'd4, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
